// File: rtl/axis_image_packer.sv
`timescale 1ns/1ps
// axis_image_packer
//   AXI-Stream width up-converter. Narrow input beats (INPUT_BYTES each) are
//   packed little-endian into wide output words (OUTPUT_BYTES each). Packet
//   boundaries are kept: an input beat with last always closes the current
//   word, and keep marks which byte lanes of a partial final word are valid.
//   A frame counter advances on every output handshake that carries last.
//
//   Handshake semantics (both sides): a transfer happens on a rising clk_i edge
//   where valid and ready are both high. A producer holds data/keep/last
//   stable while valid is high and ready is low, and never withdraws valid
//   before the transfer.
//
// Ports
//   clk_i, rstn_i     clock, asynchronous active-low reset
//   axis_s_*          narrow input stream (data, valid, ready, last)
//   axis_m_*          wide output stream (data, valid, ready, last, keep)
//   frame_cnt_o       number of output frames completed (wraps)
module axis_image_packer #(
  parameter int INPUT_BYTES    = 1,
  parameter int OUTPUT_BYTES   = 4,
  parameter int INPUT_BITS     = INPUT_BYTES * 8,
  parameter int OUTPUT_BITS    = OUTPUT_BYTES * 8,
  parameter int FRAME_CNT_BITS = 16
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [INPUT_BITS-1:0]     axis_s_data_i,
  input  logic                      axis_s_valid_i,
  output logic                      axis_s_ready_o,
  input  logic                      axis_s_last_i,
  output logic [OUTPUT_BITS-1:0]    axis_m_data_o,
  output logic                      axis_m_valid_o,
  input  logic                      axis_m_ready_i,
  output logic                      axis_m_last_o,
  output logic [OUTPUT_BYTES-1:0]   axis_m_keep_o,
  output logic [FRAME_CNT_BITS-1:0] frame_cnt_o
);

  localparam int RATIO = OUTPUT_BYTES / INPUT_BYTES;
  // Keep the lane counter at least one bit wide so RATIO == 1 still elaborates.
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  generate
    if ((OUTPUT_BYTES % INPUT_BYTES) != 0 || OUTPUT_BYTES < INPUT_BYTES) begin : g_bad_ratio
      $fatal(1, "axis_image_packer: OUTPUT_BYTES must be an integer multiple of INPUT_BYTES");
    end
  endgenerate

  logic [CNT_W-1:0]        cnt;
  logic [OUTPUT_BITS-1:0]  acc;
  logic [OUTPUT_BITS-1:0]  merged;
  logic [OUTPUT_BYTES-1:0] keep_next;
  logic                    accept;
  logic                    complete;
  logic                    m_hs;

  // Input may only advance when the output register is free or draining
  // this cycle; gated by reset so nothing is accepted while held in reset.
  assign axis_s_ready_o = rstn_i && (!axis_m_valid_o || axis_m_ready_i);
  assign accept         = axis_s_valid_i && axis_s_ready_o;
  assign complete       = accept && ((cnt == CNT_W'(RATIO - 1)) || axis_s_last_i);
  assign m_hs           = axis_m_valid_o && axis_m_ready_i;

  // Current beat merged into its lane. Lanes above cnt are already zero
  // because the accumulator is cleared whenever a word is emitted.
  always_comb begin
    merged = acc;
    merged[int'(cnt) * INPUT_BITS +: INPUT_BITS] = axis_s_data_i;
    keep_next = '0;
    for (int b = 0; b < OUTPUT_BYTES; b++) begin
      if (b < (int'(cnt) + 1) * INPUT_BYTES) begin
        keep_next[b] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt            <= '0;
      acc            <= '0;
      axis_m_data_o  <= '0;
      axis_m_keep_o  <= '0;
      axis_m_last_o  <= 1'b0;
      axis_m_valid_o <= 1'b0;
      frame_cnt_o    <= '0;
    end else begin
      if (m_hs && axis_m_last_o) begin
        frame_cnt_o <= frame_cnt_o + FRAME_CNT_BITS'(1);
      end
      if (complete) begin
        // A load in the same cycle as an output handshake simply replaces
        // the drained word, so full throughput needs no bubble.
        axis_m_data_o  <= merged;
        axis_m_keep_o  <= keep_next;
        axis_m_last_o  <= axis_s_last_i;
        axis_m_valid_o <= 1'b1;
        cnt            <= '0;
        acc            <= '0;
      end else begin
        if (m_hs) begin
          axis_m_valid_o <= 1'b0;
        end
        if (accept) begin
          acc <= merged;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_image_packer.sv
`timescale 1ns/1ps
module tb_axis_image_packer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (1 -> 4 bytes) ----------------
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_last = 1'b0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic [3:0]  m_keep;
  logic [15:0] frame_cnt;

  axis_image_packer #(.INPUT_BYTES(1), .OUTPUT_BYTES(4)) u_dut (
    .clk_i(clk), .rstn_i(rstn),
    .axis_s_data_i(s_data), .axis_s_valid_i(s_valid), .axis_s_ready_o(s_ready),
    .axis_s_last_i(s_last),
    .axis_m_data_o(m_data), .axis_m_valid_o(m_valid), .axis_m_ready_i(m_ready),
    .axis_m_last_o(m_last), .axis_m_keep_o(m_keep), .frame_cnt_o(frame_cnt)
  );

  // ---------------- DUT (2 -> 2 bytes) ----------------
  logic [15:0] s2_data = '0;
  logic        s2_valid = 1'b0;
  logic        s2_ready;
  logic        s2_last = 1'b0;
  logic [15:0] m2_data;
  logic        m2_valid;
  logic        m2_ready = 1'b1;
  logic        m2_last;
  logic [1:0]  m2_keep;
  logic [15:0] frame_cnt2;

  axis_image_packer #(.INPUT_BYTES(2), .OUTPUT_BYTES(2)) u_dut2 (
    .clk_i(clk), .rstn_i(rstn),
    .axis_s_data_i(s2_data), .axis_s_valid_i(s2_valid), .axis_s_ready_o(s2_ready),
    .axis_s_last_i(s2_last),
    .axis_m_data_o(m2_data), .axis_m_valid_o(m2_valid), .axis_m_ready_i(m2_ready),
    .axis_m_last_o(m2_last), .axis_m_keep_o(m2_keep), .frame_cnt_o(frame_cnt2)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int stall_cnt = 0;
  int words_rx = 0;
  int exp_frames = 0;
  logic rand_ready = 1'b0;
  logic [36:0] exp_q[$];   // {last, keep, data}
  logic [36:0] exp_e;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference packing model ----------------
  logic [31:0] model_word = '0;
  int          model_cnt = 0;

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [7:0] d, input logic l);
    int waited;
    waited = 0;
    s_data = d;
    s_last = l;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && waited < 1000) begin
      waited++;
      stall_cnt++;
      @(negedge clk);
    end
    if (!s_ready) check("send_timeout", {63'd0, s_ready}, 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data = 8'hEE;  // junk while idle must be ignored
    s_last = 1'b1;
  endtask

  task automatic model_beat(input logic [7:0] d, input logic l);
    logic [3:0] k;
    model_word[model_cnt*8 +: 8] = d;
    model_cnt++;
    if (model_cnt == 4 || l) begin
      k = 4'((5'd1 << model_cnt) - 5'd1);
      exp_q.push_back({l, k, model_word});
      model_word = '0;
      model_cnt = 0;
    end
    send_beat(d, l);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && m_valid && m_ready) begin
        words_rx++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=0x%0h expected=none at %0t", {m_last, m_keep, m_data}, $time);
        end else begin
          exp_e = exp_q.pop_front();
          check("out_word", {27'd0, m_last, m_keep, m_data}, {27'd0, exp_e});
          if (exp_e[36]) exp_frames++;
        end
      end
    end
  end

  // random output backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    end
  end

  // watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic        exp_word;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
  } vec_t;

  vec_t vecs[14];
  logic [7:0] long_data[4096];

  initial begin
    vecs[0]  = '{8'h11, 1'b0, 1'b0, 32'h0, 4'h0};
    vecs[1]  = '{8'h22, 1'b0, 1'b0, 32'h0, 4'h0};
    vecs[2]  = '{8'h33, 1'b0, 1'b0, 32'h0, 4'h0};
    vecs[3]  = '{8'h44, 1'b1, 1'b1, 32'h44332211, 4'hF};
    vecs[4]  = '{8'h01, 1'b0, 1'b0, 32'h0, 4'h0};
    vecs[5]  = '{8'h02, 1'b0, 1'b0, 32'h0, 4'h0};
    vecs[6]  = '{8'h03, 1'b0, 1'b0, 32'h0, 4'h0};
    vecs[7]  = '{8'h04, 1'b0, 1'b1, 32'h04030201, 4'hF};
    vecs[8]  = '{8'h05, 1'b0, 1'b0, 32'h0, 4'h0};
    vecs[9]  = '{8'h06, 1'b1, 1'b1, 32'h00000605, 4'h3};
    vecs[10] = '{8'h7E, 1'b1, 1'b1, 32'h0000007E, 4'h1};
    vecs[11] = '{8'hA1, 1'b0, 1'b0, 32'h0, 4'h0};
    vecs[12] = '{8'hB2, 1'b0, 1'b0, 32'h0, 4'h0};
    vecs[13] = '{8'hC3, 1'b1, 1'b1, 32'h00C3B2A1, 4'h7};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    s_valid = 1'b1;  // ready must stay low under reset regardless
    check("rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_data", {32'd0, m_data}, 64'd0);
    check("rst_m_keep", {60'd0, m_keep}, 64'd0);
    check("rst_m_last", {63'd0, m_last}, 64'd0);
    check("rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // ---- table: packing, partial words, lane-0 last, 1-cycle latency ----
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].exp_word) exp_q.push_back({vecs[i].last, vecs[i].exp_keep, vecs[i].exp_data});
      send_beat(vecs[i].data, vecs[i].last);
      check("latency_valid", {63'd0, m_valid}, {63'd0, vecs[i].exp_word});
    end
    wait_drain("drain_table");
    check("frame_cnt_table", {48'd0, frame_cnt}, 64'(exp_frames));

    // ---- backpressure: full word pending, input stalls, nothing lost ----
    m_ready = 1'b0;
    model_beat(8'h51, 1'b0);
    model_beat(8'h52, 1'b0);
    model_beat(8'h53, 1'b0);
    model_beat(8'h54, 1'b0);
    s_data = 8'h61;
    s_last = 1'b0;
    s_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_s_ready", {63'd0, s_ready}, 64'd0);
      check("bp_m_valid", {63'd0, m_valid}, 64'd1);
      check("bp_m_data", {32'd0, m_data}, 64'h54535251);
      check("bp_m_keep", {60'd0, m_keep}, 64'hF);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    stall_cnt = 0;
    model_beat(8'h61, 1'b0);
    check("bp_resume_stall", 64'(stall_cnt), 64'd0);
    check("bp_drained_valid", {63'd0, m_valid}, 64'd0);
    model_beat(8'h62, 1'b0);
    model_beat(8'h63, 1'b0);
    model_beat(8'h64, 1'b1);
    wait_drain("drain_bp");
    check("frame_cnt_bp", {48'd0, frame_cnt}, 64'(exp_frames));

    // ---- long frame, full throughput ----
    for (int i = 0; i < 4096; i++) long_data[i] = 8'($urandom_range(0, 255));
    stall_cnt = 0;
    words_rx = 0;
    for (int i = 0; i < 4096; i++) model_beat(long_data[i], (i == 4095) ? 1'b1 : 1'b0);
    wait_drain("drain_long");
    check("long_stalls", 64'(stall_cnt), 64'd0);
    check("long_words", 64'(words_rx), 64'd1024);
    check("frame_cnt_long", {48'd0, frame_cnt}, 64'(exp_frames));

    // ---- same frame, random output backpressure ----
    words_rx = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 4096; i++) model_beat(long_data[i], (i == 4095) ? 1'b1 : 1'b0);
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    wait_drain("drain_rand");
    check("rand_words", 64'(words_rx), 64'd1024);
    check("frame_cnt_rand", {48'd0, frame_cnt}, 64'(exp_frames));

    // ---- reset mid-frame discards the partial word ----
    send_beat(8'h31, 1'b0);
    send_beat(8'h32, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("mid_rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("mid_rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_frames = 0;
    words_rx = 0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", {63'd0, m_valid}, 64'd0);
    model_beat(8'hA0, 1'b0);
    model_beat(8'hA1, 1'b0);
    model_beat(8'hA2, 1'b0);
    model_beat(8'hA3, 1'b1);
    wait_drain("drain_rst");
    check("rst_words", 64'(words_rx), 64'd1);
    check("frame_cnt_rst", {48'd0, frame_cnt}, 64'd1);

    // ---- 2 -> 2 byte configuration: registered pass-through ----
    check("r1_idle_valid", {63'd0, m2_valid}, 64'd0);
    s2_data = 16'hBEEF;
    s2_last = 1'b1;
    s2_valid = 1'b1;
    @(negedge clk);
    check("r1_s_ready", {63'd0, s2_ready}, 64'd1);
    @(posedge clk);
    #1;
    s2_valid = 1'b0;
    s2_data = 16'h0000;
    check("r1_m_valid", {63'd0, m2_valid}, 64'd1);
    check("r1_m_data", {48'd0, m2_data}, 64'hBEEF);
    check("r1_m_keep", {62'd0, m2_keep}, 64'h3);
    check("r1_m_last", {63'd0, m2_last}, 64'd1);
    @(posedge clk);
    #1;
    check("r1_m_valid_after", {63'd0, m2_valid}, 64'd0);
    check("r1_frame_cnt", {48'd0, frame_cnt2}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_image_packer.md
Name: axis_image_packer

Overview:
- Synthesizable AXI-Stream width up-converter and the DUT-side counterpart of the image VIP.
- Consumes the VIP's narrow pixel stream (INPUT_BYTES per beat) and packs consecutive beats little-endian into wide words (OUTPUT_BYTES per beat), which it returns to the VIP sink.
- Preserves packet boundaries via last and flags valid byte lanes on partial final words.
- Counts completed frames for debug.

Parameters:
- INPUT_BYTES, 1, bytes per input beat.
- OUTPUT_BYTES, 4, bytes per output beat; must be an integer multiple of INPUT_BYTES (R = OUTPUT_BYTES/INPUT_BYTES ≥ 1), otherwise $fatal at elaboration.
- INPUT_BITS, INPUT_BYTES*8, input data width.
- OUTPUT_BITS, OUTPUT_BYTES*8, output data width.
- FRAME_CNT_BITS, 16, width of frame counter.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- axis_s_data_i  in  INPUT_BITS  input pixel data.
- axis_s_valid_i  in  1  input valid.
- axis_s_ready_o  out  1  input ready.
- axis_s_last_i  in  1  last beat of frame.
- axis_m_data_o  out  OUTPUT_BITS  packed output word.
- axis_m_valid_o  out  1  output valid.
- axis_m_ready_i  in  1  output ready.
- axis_m_last_o  out  1  last word of frame.
- axis_m_keep_o  out  OUTPUT_BYTES  byte-lane valid mask.
- frame_cnt_o  out  FRAME_CNT_BITS  count of output frames completed.

Behaviour:
- Reset, asynchronous on rstn_i low:
  - axis_m_valid_o=0, axis_m_last_o=0, axis_m_data_o=0, axis_m_keep_o=0, frame_cnt_o=0.
  - Lane counter cnt=0, accumulator cleared.
  - axis_s_ready_o=0 while rstn_i low (gated combinationally with rstn_i).
- Input handshake:
  - axis_s_ready_o = rstn_i && (!axis_m_valid_o || axis_m_ready_i).
  - Accept occurs on axis_s_valid_i && axis_s_ready_o at posedge.
- On accept:
  - Input data is written to lane slot cnt, occupying bits [cnt*INPUT_BITS +: INPUT_BITS].
  - If cnt==R-1 or axis_s_last_i=1, load the output register:
    - data = accumulator merged with the current beat, with unfilled lanes forced to 0;
    - keep = ones for bytes 0..(cnt+1)*INPUT_BYTES-1;
    - last = axis_s_last_i;
    - valid = 1.
    - Then cnt←0 and the accumulator is cleared.
  - Otherwise cnt←cnt+1 and the output register is untouched.
- Output handshake:
  - On axis_m_valid_o && axis_m_ready_i with no new load that cycle, valid←0.
  - A load in the same cycle overwrites the register; no bubble, no loss.
  - Data, keep and last are held stable while valid && !ready.
- Latency: 1 cycle from accept of the completing beat to axis_m_valid_o=1.
- Throughput: with axis_m_ready_i held 1, one input beat is accepted every cycle.
- R==1: behaves as a 1-deep registered pipeline with keep all ones.
- frame_cnt_o increments by 1 on each output handshake with axis_m_last_o=1. It wraps modulo 2^FRAME_CNT_BITS.
- Boundaries:
  - last on a lane-0 beat produces a word with keep showing only lane 0.
  - Back-to-back frames never share an output word.
  - Backpressure stalls input only; partial accumulator contents are retained.
- Reset mid-operation discards the partial word and any pending output. No output beat is emitted after reset deassertion until R new beats or a new last are accepted.
- axis_s_data_i and axis_s_last_i are ignored when not accepted.

Test Plan (INPUT_BYTES=1, OUTPUT_BYTES=4 unless noted):
- Beats 0x11,0x22,0x33,0x44 (last on 0x44), m_ready=1:
  - one output word 0x44332211, keep=0xF, last=1, one cycle after the fourth accept;
  - frame_cnt_o=1.
- Beats 0x01..0x06 with last on 0x06:
  - word 0x04030201 keep=0xF last=0;
  - then 0x00000605 keep=0x3 last=1.
- Hold m_ready=0 with a full word pending, keep s_valid=1:
  - s_ready=0;
  - output held stable for 5 cycles;
  - raise m_ready: word accepted, input resumes same cycle, no data lost.
- Continuous 4096-beat frame with m_ready=1:
  - 1024 words, s_ready never deasserts, data matches a reference model;
  - randomized m_ready at 50%: same word sequence.
- Assert rstn_i low after 2 of 4 beats, release, send 0xA0..0xA3 with last:
  - only 0xA3A2A1A0 keep=0xF emitted;
  - frame_cnt_o=1.
- Config IN=2, OUT=2:
  - beat 0xBEEF last=1 gives 0xBEEF keep=0x3 last=1 one cycle later.
- Config IN=3, OUT=4: elaboration fails with $fatal.
